parking_lane_counter: RTL

- Multi-lane successor to the single-lane entry/exit sensor FSM.
- Each of LANES lanes has a sensor pair a (outer) and b (inner), decoded by its own direction FSM with stuck-sensor timeout.
- Per-lane entry/exit events feed a shared saturating occupancy counter with full/empty and sticky error flags.
- Sits between sensor input synchronisers and the display/barrier controller.

---
 rtl/parking_lane_counter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/parking_lane_counter.sv
// parking_lane_counter: per-lane entry/exit direction decoders with a
// stuck-sensor timeout, feeding one shared saturating occupancy counter.
module parking_lane_counter #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 50,
  parameter int CNT_W    = $clog2(CAPACITY + 1),
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] lane_in,
  output logic [LANES-1:0] lane_out,
  output logic [LANES-1:0] lane_fault,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_over,
  output logic             err_under
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + $clog2(LANES) + 2;

  localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic signed [SUM_W-1:0] CAP_S    = SUM_W'(CAPACITY);
  localparam logic [CNT_W-1:0]        CAP_C    = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A,
    FAULT
  } lane_state_t;

  // ---------------------------------------------------------------------
  // Per-lane direction decoders
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      lane_state_t      state_reg;
      logic [TMO_W-1:0] tmo_reg;
      logic             in_reg;
      logic             out_reg;
      logic [1:0]       ab;
      logic             tmo_hit;

      assign ab = {a[gi], b[gi]};
      // A lane that has sat in any active state for TIMEOUT cycles is stuck.
      assign tmo_hit = (state_reg != IDLE) && (state_reg != FAULT) && (tmo_reg == TMO_LAST);

      // Lane FSM: decode the a/b beam sequence, timeout overrides the decode.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          tmo_reg   <= '0;
          in_reg    <= 1'b0;
          out_reg   <= 1'b0;
        end else begin
          in_reg  <= 1'b0;
          out_reg <= 1'b0;
          if (tmo_hit) begin
            state_reg <= FAULT;
            tmo_reg   <= '0;
          end else begin
            // Count time spent in active states; branches that return to
            // IDLE clear it again below.
            tmo_reg <= (state_reg == IDLE || state_reg == FAULT) ? '0 : tmo_reg + 1'b1;
            case (state_reg)
              IDLE: begin
                if (ab == 2'b10)      state_reg <= EN_A;
                else if (ab == 2'b01) state_reg <= EX_B;
              end
              EN_A: begin
                case (ab)
                  2'b11:        state_reg <= EN_AB;
                  2'b00, 2'b01: begin state_reg <= IDLE; tmo_reg <= '0; end
                  default:      ;
                endcase
              end
              EN_AB: begin
                case (ab)
                  2'b01:   state_reg <= EN_B;
                  2'b10:   state_reg <= EN_A;
                  2'b00:   begin state_reg <= IDLE; tmo_reg <= '0; end
                  default: ;
                endcase
              end
              EN_B: begin
                case (ab)
                  2'b11:   state_reg <= EN_AB;
                  2'b10:   begin state_reg <= IDLE; tmo_reg <= '0; end
                  2'b00:   begin state_reg <= IDLE; tmo_reg <= '0; in_reg <= 1'b1; end
                  default: ;
                endcase
              end
              EX_B: begin
                case (ab)
                  2'b11:        state_reg <= EX_BA;
                  2'b00, 2'b10: begin state_reg <= IDLE; tmo_reg <= '0; end
                  default:      ;
                endcase
              end
              EX_BA: begin
                case (ab)
                  2'b10:   state_reg <= EX_A;
                  2'b01:   state_reg <= EX_B;
                  2'b00:   begin state_reg <= IDLE; tmo_reg <= '0; end
                  default: ;
                endcase
              end
              EX_A: begin
                case (ab)
                  2'b11:   state_reg <= EX_BA;
                  2'b01:   begin state_reg <= IDLE; tmo_reg <= '0; end
                  2'b00:   begin state_reg <= IDLE; tmo_reg <= '0; out_reg <= 1'b1; end
                  default: ;
                endcase
              end
              FAULT: begin
                // Leave FAULT only once both beams are clear.
                if (ab == 2'b00) state_reg <= IDLE;
              end
              default: begin
                state_reg <= IDLE;
                tmo_reg   <= '0;
              end
            endcase
          end
        end
      end

      assign lane_in[gi]    = in_reg;
      assign lane_out[gi]   = out_reg;
      assign lane_fault[gi] = (state_reg == FAULT);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Shared occupancy counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]        count_reg;
  logic                    err_over_reg;
  logic                    err_under_reg;
  logic [PC_W-1:0]         n_in;
  logic [PC_W-1:0]         n_out;
  logic signed [SUM_W-1:0] sum_next;

  // Count entry and exit pulses across all lanes this cycle.
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < LANES; i++) begin
      n_in  = n_in  + PC_W'(lane_in[i]);
      n_out = n_out + PC_W'(lane_out[i]);
    end
  end

  // Entries and exits net out first, so simultaneous in/out never saturates.
  assign sum_next = $signed(SUM_W'(count_reg)) + $signed(SUM_W'(n_in)) - $signed(SUM_W'(n_out));

  // Saturating occupancy update with sticky overflow/underflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      err_over_reg  <= 1'b0;
      err_under_reg <= 1'b0;
    end else if (sum_next > CAP_S) begin
      count_reg    <= CAP_C;
      err_over_reg <= 1'b1;
    end else if (sum_next[SUM_W-1]) begin
      count_reg     <= '0;
      err_under_reg <= 1'b1;
    end else begin
      count_reg <= CNT_W'(sum_next);
    end
  end

  assign count     = count_reg;
  assign full      = (count_reg == CAP_C);
  assign empty     = (count_reg == '0);
  assign err_over  = err_over_reg;
  assign err_under = err_under_reg;

endmodule
